// File: rtl/msi_proc_side_ctrl.sv
// Processor-side MSI controller for one cache line: turns CPU requests
// into bus messages; shares the line state with the bus-side snoop FSM.
//
// Ports:
//   clock, resetn           clock, async active-low reset
//   cpu_valid/op/hit/ready  CPU request (op 0 read, 1 write), done pulse
//   bus_req/grant           bus arbitration handshake
//   bus_msg/bus_msg_valid   00 readMiss, 01 invalidate, 10 writeMiss
//   writeback               write back the current block with the message
//   snoop_valid/state       line state override from the bus-side FSM
//   state                   current line state (00 I, 01 E, 10 S)
module msi_proc_side_ctrl #(
    parameter logic [1:0] RESET_STATE = 2'b00
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cpu_valid,
    input  logic       cpu_op,
    input  logic       cpu_hit,
    output logic       cpu_ready,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic [1:0] bus_msg,
    output logic       bus_msg_valid,
    output logic       writeback,
    input  logic       snoop_valid,
    input  logic [1:0] snoop_state,
    output logic [1:0] state
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_E = 2'b01;
    localparam logic [1:0] ST_S = 2'b10;

    localparam logic [1:0] MSG_RM  = 2'b00;
    localparam logic [1:0] MSG_INV = 2'b01;
    localparam logic [1:0] MSG_WM  = 2'b10;

    typedef enum logic {
        IDLE,
        ARB
    } fsm_t;

    fsm_t       fsm, fsm_n;
    logic [1:0] pend_msg, pend_msg_n;
    logic       pend_wb, pend_wb_n;
    logic [1:0] target, target_n;

    logic       cpu_ready_n;
    logic       bus_req_n;
    logic [1:0] bus_msg_n;
    logic       bus_msg_valid_n;
    logic       writeback_n;
    logic [1:0] state_n;

    logic [1:0] es;
    logic       miss;
    logic       evict;
    logic [1:0] adj_msg;
    logic       adj_wb;

    assign es    = snoop_valid ? snoop_state : state;
    assign miss  = !cpu_hit || (es == ST_I);
    // Conflict miss on a dirty line: old block must go out first.
    assign evict = (es == ST_E) && !cpu_hit;

    // A pending upgrade becomes a writeMiss if our copy is invalidated;
    // any snoop leaving exclusive means the bus side already wrote back.
    always_comb begin
        adj_msg = pend_msg;
        adj_wb  = pend_wb;
        if (snoop_valid && snoop_state == ST_I && pend_msg == MSG_INV)
            adj_msg = MSG_WM;
        if (snoop_valid && snoop_state != ST_E)
            adj_wb = 1'b0;
    end

    always_comb begin
        fsm_n           = fsm;
        pend_msg_n      = pend_msg;
        pend_wb_n       = pend_wb;
        target_n        = target;
        cpu_ready_n     = 1'b0;
        bus_req_n       = 1'b0;
        bus_msg_n       = MSG_RM;
        bus_msg_valid_n = 1'b0;
        writeback_n     = 1'b0;
        state_n         = es;
        unique case (fsm)
            IDLE: begin
                if (cpu_valid && !cpu_ready) begin
                    if (!cpu_op && !miss) begin
                        cpu_ready_n = 1'b1;
                    end else if (cpu_op && !miss && es == ST_E) begin
                        cpu_ready_n = 1'b1;
                    end else if (cpu_op && !miss) begin
                        pend_msg_n = MSG_INV;
                        pend_wb_n  = 1'b0;
                        target_n   = ST_E;
                        bus_req_n  = 1'b1;
                        fsm_n      = ARB;
                    end else begin
                        pend_msg_n = cpu_op ? MSG_WM : MSG_RM;
                        pend_wb_n  = evict;
                        target_n   = cpu_op ? ST_E : ST_S;
                        bus_req_n  = 1'b1;
                        fsm_n      = ARB;
                    end
                end
            end
            ARB: begin
                pend_msg_n = adj_msg;
                pend_wb_n  = adj_wb;
                bus_req_n  = 1'b1;
                if (bus_grant) begin
                    bus_msg_n       = adj_msg;
                    bus_msg_valid_n = 1'b1;
                    cpu_ready_n     = 1'b1;
                    writeback_n     = adj_wb;
                    state_n         = target;
                    bus_req_n       = 1'b0;
                    fsm_n           = IDLE;
                end
            end
            default: fsm_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fsm           <= IDLE;
            pend_msg      <= MSG_RM;
            pend_wb       <= 1'b0;
            target        <= ST_I;
            cpu_ready     <= 1'b0;
            bus_req       <= 1'b0;
            bus_msg       <= MSG_RM;
            bus_msg_valid <= 1'b0;
            writeback     <= 1'b0;
            state         <= RESET_STATE;
        end else begin
            fsm           <= fsm_n;
            pend_msg      <= pend_msg_n;
            pend_wb       <= pend_wb_n;
            target        <= target_n;
            cpu_ready     <= cpu_ready_n;
            bus_req       <= bus_req_n;
            bus_msg       <= bus_msg_n;
            bus_msg_valid <= bus_msg_valid_n;
            writeback     <= writeback_n;
            state         <= state_n;
        end
    end

endmodule

// File: tb/tb_msi_proc_side_ctrl.sv
// Directed bench for msi_proc_side_ctrl (RESET_STATE = shared).
// Drives inputs 1 ns after each rising edge and checks outputs there.
module tb_msi_proc_side_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       cpu_valid = 1'b0;
    logic       cpu_op = 1'b0;
    logic       cpu_hit = 1'b0;
    logic       cpu_ready;
    logic       bus_req;
    logic       bus_grant = 1'b0;
    logic [1:0] bus_msg;
    logic       bus_msg_valid;
    logic       writeback;
    logic       snoop_valid = 1'b0;
    logic [1:0] snoop_state = 2'b00;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    msi_proc_side_ctrl #(.RESET_STATE(2'b10)) dut (
        .clock(clock),
        .resetn(resetn),
        .cpu_valid(cpu_valid),
        .cpu_op(cpu_op),
        .cpu_hit(cpu_hit),
        .cpu_ready(cpu_ready),
        .bus_req(bus_req),
        .bus_grant(bus_grant),
        .bus_msg(bus_msg),
        .bus_msg_valid(bus_msg_valid),
        .writeback(writeback),
        .snoop_valid(snoop_valid),
        .snoop_state(snoop_state),
        .state(state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every output in one go.
    task automatic chk_all(input string tag, input logic [1:0] st,
                           input logic rq, input logic [1:0] msg,
                           input logic mv, input logic rdy,
                           input logic wb);
        chk({tag, ".state"}, state, st);
        chk({tag, ".bus_req"}, {1'b0, bus_req}, {1'b0, rq});
        chk({tag, ".bus_msg"}, bus_msg, msg);
        chk({tag, ".msg_valid"}, {1'b0, bus_msg_valid}, {1'b0, mv});
        chk({tag, ".cpu_ready"}, {1'b0, cpu_ready}, {1'b0, rdy});
        chk({tag, ".writeback"}, {1'b0, writeback}, {1'b0, wb});
    endtask

    initial begin
        // async reset before any clock edge
        #3 resetn = 1'b0;
        #1 chk_all("reset", 2'b10, 0, 2'b00, 0, 0, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk_all("post_reset", 2'b10, 0, 2'b00, 0, 0, 0);

        // snoop in idle forces invalid
        snoop_valid = 1'b1; snoop_state = 2'b00;
        tick();
        snoop_valid = 1'b0;
        chk("idle_snoop.state", state, 2'b00);

        // read miss from invalid, grant two cycles later
        cpu_valid = 1'b1; cpu_op = 1'b0; cpu_hit = 1'b1;
        tick();
        chk_all("rm.e0", 2'b00, 1, 2'b00, 0, 0, 0);
        tick();
        chk_all("rm.e1", 2'b00, 1, 2'b00, 0, 0, 0);
        bus_grant = 1'b1;
        tick();
        chk_all("rm.grant", 2'b10, 0, 2'b00, 1, 1, 0);
        cpu_valid = 1'b0; bus_grant = 1'b0;
        tick();
        chk_all("rm.after", 2'b10, 0, 2'b00, 0, 0, 0);

        // write hit in shared: upgrade via invalidate
        cpu_valid = 1'b1; cpu_op = 1'b1; cpu_hit = 1'b1;
        tick();
        chk_all("up.e0", 2'b10, 1, 2'b00, 0, 0, 0);
        bus_grant = 1'b1;
        tick();
        chk_all("up.grant", 2'b01, 0, 2'b01, 1, 1, 0);
        cpu_valid = 1'b0; bus_grant = 1'b0;
        tick();
        chk_all("up.after", 2'b01, 0, 2'b00, 0, 0, 0);

        // follow-up write hit in exclusive
        cpu_valid = 1'b1; cpu_op = 1'b1; cpu_hit = 1'b1;
        tick();
        chk_all("wh", 2'b01, 0, 2'b00, 0, 1, 0);
        cpu_valid = 1'b0;
        tick();
        chk_all("wh.after", 2'b01, 0, 2'b00, 0, 0, 0);

        // grant while idle is ignored
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        chk_all("idle_grant", 2'b01, 0, 2'b00, 0, 0, 0);

        // dirty conflict eviction on read miss
        cpu_valid = 1'b1; cpu_op = 1'b0; cpu_hit = 1'b0;
        tick();
        chk_all("ev.e0", 2'b01, 1, 2'b00, 0, 0, 0);
        bus_grant = 1'b1;
        tick();
        chk_all("ev.grant", 2'b10, 0, 2'b00, 1, 1, 1);
        cpu_valid = 1'b0; bus_grant = 1'b0;
        tick();

        // upgrade race: copy invalidated while arbitrating
        cpu_valid = 1'b1; cpu_op = 1'b1; cpu_hit = 1'b1;
        tick();
        chk_all("race.e0", 2'b10, 1, 2'b00, 0, 0, 0);
        snoop_valid = 1'b1; snoop_state = 2'b00;
        tick();
        snoop_valid = 1'b0;
        chk_all("race.snoop", 2'b00, 1, 2'b00, 0, 0, 0);
        bus_grant = 1'b1;
        tick();
        chk_all("race.grant", 2'b01, 0, 2'b10, 1, 1, 0);
        cpu_valid = 1'b0; bus_grant = 1'b0;
        tick();

        // dirty eviction whose writeback is cleared by a snoop
        cpu_valid = 1'b1; cpu_op = 1'b1; cpu_hit = 1'b0;
        tick();
        chk_all("wbclr.e0", 2'b01, 1, 2'b00, 0, 0, 0);
        snoop_valid = 1'b1; snoop_state = 2'b10; bus_grant = 1'b1;
        tick();
        snoop_valid = 1'b0;
        chk_all("wbclr.grant", 2'b01, 0, 2'b10, 1, 1, 0);
        cpu_valid = 1'b0; bus_grant = 1'b0;
        tick();

        // reset mid-ARB abandons the request
        cpu_valid = 1'b1; cpu_op = 1'b0; cpu_hit = 1'b0;
        tick();
        chk("rst_arb.req", {1'b0, bus_req}, 2'b01);
        #2 resetn = 1'b0;
        cpu_valid = 1'b0;
        #1 chk_all("rst_arb.reset", 2'b10, 0, 2'b00, 0, 0, 0);
        tick();
        resetn = 1'b1;
        bus_grant = 1'b1;
        tick();
        chk_all("rst_arb.grant", 2'b10, 0, 2'b00, 0, 0, 0);
        bus_grant = 1'b0;
        tick();

        // snoop and acceptance on the same edge
        cpu_valid = 1'b1; cpu_op = 1'b1; cpu_hit = 1'b1;
        snoop_valid = 1'b1; snoop_state = 2'b01;
        tick();
        snoop_valid = 1'b0; cpu_valid = 1'b0;
        chk_all("snp_acc", 2'b01, 0, 2'b00, 0, 1, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
